// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, STEP bits per
// clock, with sign fix-up folded into the final iteration. Division by zero and
// the signed overflow case bypass the iteration and answer one cycle after accept.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  // request decode
  logic            accept;
  logic            req_is_div;
  logic [1:0]      req_fn;
  logic            src1_neg, src2_neg;
  logic [XLEN-1:0] src1_mag, src2_mag;
  logic            div_by_zero, div_overflow, special;
  logic [XLEN-1:0] special_result;

  // operation state; hi/lo hold partial product or remainder/quotient
  logic             is_div_reg;
  logic [1:0]       fn_reg;
  logic             neg_reg;
  logic [XLEN-1:0]  hi_reg, lo_reg, opnd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [XLEN-1:0]  resp_result_reg;
  logic [TAG_W-1:0] resp_tag_reg;

  logic [XLEN-1:0]   stage_hi [STEP+1];
  logic [XLEN-1:0]   stage_lo [STEP+1];
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  assign req_ready   = (state_reg == IDLE) && !flush && !rst;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_reg == DONE);
  assign resp_result = resp_result_reg;
  assign resp_tag    = resp_tag_reg;

  // Operand signedness, magnitudes and special-case detection from the live request
  always_comb begin
    logic s1_signed, s2_signed;
    req_is_div = req_op[2];
    req_fn     = req_op[1:0];
    // MUL is treated as unsigned: its low half is identical either way
    s1_signed  = req_is_div ? !req_fn[0] : (req_fn == 2'b01 || req_fn == 2'b10);
    s2_signed  = req_is_div ? !req_fn[0] : (req_fn == 2'b01);
    src1_neg   = s1_signed && req_src1[XLEN-1];
    src2_neg   = s2_signed && req_src2[XLEN-1];
    src1_mag   = src1_neg ? -req_src1 : req_src1;
    src2_mag   = src2_neg ? -req_src2 : req_src2;
    div_by_zero  = req_is_div && (req_src2 == '0);
    div_overflow = req_is_div && !req_fn[0] &&
                   (req_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_src2 == '1);
    special      = div_by_zero || div_overflow;
    if (div_by_zero) special_result = req_fn[1] ? req_src1 : '1;
    else             special_result = req_fn[1] ? '0 : req_src1;
  end

  // Unrolled chain of STEP single-bit multiply/divide iterations
  assign stage_hi[0] = hi_reg;
  assign stage_lo[0] = lo_reg;
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      logic [XLEN:0] mul_sum;
      logic [XLEN:0] div_trial;
      assign mul_sum   = {1'b0, stage_hi[gi]} + (stage_lo[gi][0] ? {1'b0, opnd_reg} : '0);
      assign div_trial = {stage_hi[gi], stage_lo[gi][XLEN-1]} - {1'b0, opnd_reg};
      assign stage_hi[gi+1] = !is_div_reg ? mul_sum[XLEN:1] :
                              div_trial[XLEN] ? {stage_hi[gi][XLEN-2:0], stage_lo[gi][XLEN-1]} :
                              div_trial[XLEN-1:0];
      assign stage_lo[gi+1] = !is_div_reg ? {mul_sum[0], stage_lo[gi][XLEN-1:1]} :
                              {stage_lo[gi][XLEN-2:0], !div_trial[XLEN]};
    end
  endgenerate

  // Sign-corrected result of the last iteration, selected by operation
  always_comb begin
    prod     = {stage_hi[STEP], stage_lo[STEP]};
    prod_fix = neg_reg ? -prod : prod;
    quo_fix  = neg_reg ? -stage_lo[STEP] : stage_lo[STEP];
    rem_fix  = neg_reg ? -stage_hi[STEP] : stage_hi[STEP];
    if (!is_div_reg) final_result = (fn_reg == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else             final_result = fn_reg[1] ? rem_fix : quo_fix;
  end

  // Next-state logic; flush forces IDLE over any other transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : BUSY;
      BUSY:    if (cnt_reg == CNT_LAST) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand latch on accept, one STEP group per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_reg <= 1'b0;
      fn_reg     <= '0;
      neg_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      cnt_reg    <= '0;
      tag_reg    <= '0;
    end else if (accept) begin
      is_div_reg <= req_is_div;
      fn_reg     <= req_fn;
      // REM follows the dividend sign; every other op negates when signs differ
      neg_reg    <= (req_is_div && req_fn[1]) ? src1_neg : (src1_neg ^ src2_neg);
      hi_reg     <= '0;
      lo_reg     <= req_is_div ? src1_mag : src2_mag;
      opnd_reg   <= req_is_div ? src2_mag : src1_mag;
      cnt_reg    <= '0;
      tag_reg    <= req_tag;
    end else if (state_reg == BUSY) begin
      if (flush) begin
        cnt_reg <= '0;
      end else begin
        hi_reg  <= stage_hi[STEP];
        lo_reg  <= stage_lo[STEP];
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Response registers, loaded only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_result_reg <= '0;
      resp_tag_reg    <= '0;
    end else if (state_reg != DONE && state_next == DONE) begin
      resp_result_reg <= (state_reg == IDLE) ? special_result : final_result;
      resp_tag_reg    <= (state_reg == IDLE) ? req_tag : tag_reg;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: STEP=1 and STEP=4 instances driven from a table of
// hand-computed vectors, plus directed backpressure, flush and reset sequences.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, flush, req_valid, resp_ready;
  logic [2:0]  req_op   [2];
  logic [31:0] req_src1 [2];
  logic [31:0] req_src2 [2];
  logic [4:0]  req_tag  [2];
  wire  [1:0]  req_ready, resp_valid;
  wire  [31:0] resp_result [2];
  wire  [4:0]  resp_tag    [2];

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .STEP(1), .TAG_W(5)) u_dut1 (
    .clk(clk), .rst(rst[0]), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_src1(req_src1[0]), .req_src2(req_src2[0]), .req_tag(req_tag[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_result(resp_result[0]), .resp_tag(resp_tag[0])
  );

  muldiv_unit #(.XLEN(32), .STEP(4), .TAG_W(5)) u_dut4 (
    .clk(clk), .rst(rst[1]), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_src1(req_src1[1]), .req_src2(req_src2[1]), .req_tag(req_tag[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_result(resp_result[1]), .resp_tag(resp_tag[1])
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its response and handshake it if resp_ready is high
  task automatic do_op(input int u, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       output logic [31:0] res, output logic [4:0] rtag, output int lat);
    int w;
    req_op[u] = op; req_src1[u] = a; req_src2[u] = b; req_tag[u] = tag;
    req_valid[u] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready[u] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("u%0d req_ready before issue", u), {31'b0, req_ready[u]}, 32'd1);
    @(posedge clk);
    #1;
    // scramble the inputs: the unit must work from its latched copy
    req_valid[u] = 1'b0;
    req_op[u] = ~op; req_src1[u] = ~a; req_src2[u] = ~b; req_tag[u] = ~tag;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[u] && lat < 200);
    res  = resp_result[u];
    rtag = resp_tag[u];
    if (resp_valid[u]) begin
      @(posedge clk);
      #1;
    end
    $display("unit %0d op %0d src1=%h src2=%h tag=%h -> result=%h rtag=%h latency=%0d",
             u, op, a, b, tag, res, rtag, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [4:0]  rtag, tag;
    int          lat, seen, exp_lat;

    //            op    src1          src2          expected      special
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}; // MUL
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}; // MULH
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}; // MULHU
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}; // MULHSU
    vecs[4]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0}; // MULH -3*5
    vecs[5]  = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0}; // MUL 2^32 low
    vecs[6]  = '{3'd3, 32'h80000000, 32'd2,        32'h00000001, 1'b0}; // MULHU
    vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0}; // DIV -7/2
    vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0}; // REM
    vecs[9]  = '{3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0}; // DIVU
    vecs[10] = '{3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001, 1'b0}; // REMU
    vecs[11] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0}; // DIV 7/-2
    vecs[12] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0}; // REM 7/-2
    vecs[13] = '{3'd7, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0}; // REMU
    vecs[14] = '{3'd5, 32'd0,        32'd5,        32'd0,        1'b0}; // DIVU 0/5
    vecs[15] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1}; // DIV by 0
    vecs[16] = '{3'd7, 32'd5,        32'd0,        32'd5,        1'b1}; // REMU by 0
    vecs[17] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}; // DIV overflow
    vecs[18] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1}; // REM overflow
    vecs[19] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1}; // REM by 0
    vecs[20] = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0}; // DIVU 100/7
    vecs[21] = '{3'd2, 32'd2,        32'hFFFFFFFF, 32'h00000001, 1'b0}; // MULHSU 2*u
    vecs[22] = '{3'd4, 32'h80000000, 32'd1,        32'h80000000, 1'b0}; // DIV min/1
    vecs[23] = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0}; // DIVU

    rst = 2'b11; flush = 2'b00; req_valid = 2'b00; resp_ready = 2'b11;
    for (int u = 0; u < 2; u++) begin
      req_op[u] = '0; req_src1[u] = '0; req_src2[u] = '0; req_tag[u] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d reset resp_valid", u), {31'b0, resp_valid[u]}, 32'd0);
      check($sformatf("u%0d reset resp_result", u), resp_result[u], 32'd0);
      check($sformatf("u%0d reset resp_tag", u), {27'b0, resp_tag[u]}, 32'd0);
      check($sformatf("u%0d req_ready in reset", u), {31'b0, req_ready[u]}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 2'b00;
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      check($sformatf("u%0d req_ready after reset", u), {31'b0, req_ready[u]}, 32'd1);
    @(posedge clk);
    #1;

    // table of vectors through both widths
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < NV; i++) begin
        tag = 5'(i * 3 + u + 1);
        do_op(u, vecs[i].op, vecs[i].a, vecs[i].b, tag, res, rtag, lat);
        exp_lat = vecs[i].special ? 1 : ((u == 0) ? 33 : 9);
        check($sformatf("u%0d v%0d result", u, i), res, vecs[i].exp);
        check($sformatf("u%0d v%0d tag", u, i), {27'b0, rtag}, {27'b0, tag});
        check($sformatf("u%0d v%0d latency", u, i), 32'(lat), 32'(exp_lat));
      end
    end

    // backpressure: response held for 10 cycles with resp_ready low
    resp_ready[0] = 1'b0;
    do_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 5'h1A, res, rtag, lat);
    check("bp result", res, 32'hFFFFFFEB);
    check("bp tag", {27'b0, rtag}, 32'h1A);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d resp_valid", k), {31'b0, resp_valid[0]}, 32'd1);
      check($sformatf("bp hold %0d result", k), resp_result[0], 32'hFFFFFFEB);
      check($sformatf("bp hold %0d tag", k), {27'b0, resp_tag[0]}, 32'h1A);
      check($sformatf("bp hold %0d req_ready", k), {31'b0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp after handshake resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("bp after handshake req_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;

    // flush in the 5th BUSY cycle
    req_op[0] = 3'd4; req_src1[0] = 32'hFFFFFFF9; req_src2[0] = 32'd2; req_tag[0] = 5'h05;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("flush issue req_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(negedge clk);
    check("flush cycle req_ready", {31'b0, req_ready[0]}, 32'd0);
    @(posedge clk);
    #1 flush[0] = 1'b0;
    @(negedge clk);
    check("after flush req_ready", {31'b0, req_ready[0]}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid[0]) seen++;
    end
    check("flushed op resp_valid count", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    do_op(0, 3'd5, 32'd100, 32'd7, 5'h0C, res, rtag, lat);
    check("post flush DIVU result", res, 32'd14);
    check("post flush DIVU latency", 32'(lat), 32'd33);

    // reset in the middle of an operation
    req_op[0] = 3'd0; req_src1[0] = 32'd7; req_src2[0] = 32'hFFFFFFFD; req_tag[0] = 5'h11;
    req_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    check("rst high req_ready", {31'b0, req_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst mid-op resp_result", resp_result[0], 32'd0);
    check("rst mid-op resp_tag", {27'b0, resp_tag[0]}, 32'd0);
    check("rst mid-op resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("after rst req_ready", {31'b0, req_ready[0]}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid[0]) seen++;
    end
    check("reset op resp_valid count", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    do_op(0, 3'd1, 32'h80000000, 32'h80000000, 5'h1F, res, rtag, lat);
    check("post rst MULH result", res, 32'h40000000);
    check("post rst MULH tag", {27'b0, rtag}, 32'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
